multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle control FSM for the CPU datapath: sequences the PC register, instruction register, register file write port, ALU operand/function selection, immediate extension and data memory through FETCH/DECODE/EXEC/MEM/WB.
- Sits beside the datapath top level. Consumes decoded opecode/funct and the ALU zero flag. Drives every enable/select the datapath leaves open.
- Also handles request/ready handshakes to instruction and data memory, with a timeout-to-fault path and a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles waiting on imem_ready/dmem_ready before FAULT; 8-bit counter, legal range 1..255.
- HALT_OP, 6'h3F: opecode that stops the machine.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- opecode  in  6  decoded IR[31:26]
- funct  in  6  decoded IR[5:0]
- alu_zero  in  1  ALU result == 0
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load (valid while dmem_req)
- dmem_ready  in  1  data access complete this cycle
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump addr, 3 = rs_data
- lr_we  out  1  latch link register
- reg_we  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- wb_src  out  1  0 = ALU, 1 = memory
- alu_src  out  1  0 = rt_data, 1 = extended immediate
- zors  out  1  0 = zero-extend, 1 = sign-extend
- alu_funct  out  6  ALU function code
- halted  out  1  HALT state reached
- fault  out  1  handshake timeout occurred
- retired  out  32  instructions completed since reset

Behaviour:
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), HALT(5), FAULT(6).
- Reset:
  - State = FETCH; retired = 0; timeout counter = 0.
  - All outputs 0, except imem_req, which is combinationally 1 in FETCH.
  - rst overrides any state, including a pending handshake: a request drops on the next cycle.
- FETCH:
  - imem_req = 1.
  - On imem_ready: ir_we = 1, pc_we = 1, pc_src = 0; go to DECODE.
  - Otherwise increment the timeout counter. Counter reaching TIMEOUT_CYCLES goes to FAULT.
- DECODE: one cycle, no enables asserted. Classify the instruction:
  - R-type: opecode 0.
  - JR: opecode 0, funct 6'h08.
  - ADDI 6'h08, ORI 6'h0D, LW 6'h23, SW 6'h2B, BEQ 6'h04, J 6'h02, JAL 6'h03, HALT_OP.
  - Unknown opecode is treated as NOP: retire, then FETCH.
- EXEC:
  - R-type: alu_src = 0, alu_funct = funct; go to WB.
  - ADDI, ORI: alu_src = 1; zors = 1 for ADDI, 0 for ORI; alu_funct = 6'h20 (ADDI) or 6'h25 (ORI); go to WB.
  - LW, SW: alu_src = 1, zors = 1, alu_funct = 6'h20; go to MEM.
  - BEQ: alu_src = 0, alu_funct = 6'h22; pc_we = alu_zero, pc_src = 1; retire; go to FETCH.
  - J: pc_we = 1, pc_src = 2; retire; go to FETCH.
  - JAL: as J, plus lr_we = 1 in the same cycle, capturing the already-incremented PC.
  - JR: pc_we = 1, pc_src = 3; retire; go to FETCH.
  - HALT_OP: go to HALT without retiring.
- MEM:
  - dmem_req = 1; dmem_we = 1 for SW; ALU selects held stable.
  - On dmem_ready: LW goes to WB; SW retires and goes to FETCH.
  - Same timeout rule as FETCH.
- WB:
  - reg_we = 1 for exactly one cycle.
  - reg_dst = 1 for R-type, 0 otherwise; wb_src = 1 for LW only.
  - Retire; go to FETCH.
- Retire: retired increments by 1, wrapping 0xFFFFFFFF -> 0.
- Timeout counter: cleared on every state entry and on ready. Ready in the same cycle the counter hits the limit wins: no fault.
- HALT, FAULT:
  - Terminal; only rst exits.
  - halted = 1 (HALT) or fault = 1 (FAULT), held.
  - No enables asserted, no memory requests.
- Enables (ir_we, pc_we, lr_we, reg_we) are Moore or state-qualified, never asserted outside their listed state.
- alu_funct and selects hold the EXEC values through MEM and WB.

Test Plan:
- ADD r3 = r1 + r2 (opecode 0, funct 6'h20), imem_ready on first cycle:
  - FETCH, DECODE, EXEC, WB = 4 cycles.
  - reg_we = 1 only in WB with reg_dst = 1, wb_src = 0.
  - retired 0 -> 1.
- LW with dmem_ready delayed 3 cycles:
  - dmem_req high 4 cycles, dmem_we = 0.
  - Then WB with wb_src = 1, reg_dst = 0, zors = 1.
  - Total 8 cycles.
- BEQ twice:
  - alu_zero = 1: pc_we = 1, pc_src = 1 in EXEC.
  - alu_zero = 0: pc_we = 0.
  - Both retire and return to FETCH.
- JAL: lr_we = 1 and pc_we = 1 with pc_src = 2 in the same EXEC cycle; reg_we never asserted.
- Timeouts:
  - imem_ready held low: fault = 1 after exactly 64 FETCH cycles, imem_req = 0 afterwards.
  - imem_ready rising on cycle 64: no fault.
- Mid-operation reset and halt:
  - rst during MEM with dmem_req high: next cycle state = FETCH, dmem_req = 0, retired = 0.
  - Opecode 6'h3F: halted = 1, retired unchanged.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshakes, a handshake timeout to FAULT, and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [5:0]  HALT_OP        = 6'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opecode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        lr_we,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        wb_src,
  output logic        alu_src,
  output logic        zors,
  output logic [5:0]  alu_funct,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_NOP   = 4'd0,
    C_RTYPE = 4'd1,
    C_JR    = 4'd2,
    C_ADDI  = 4'd3,
    C_ORI   = 4'd4,
    C_LW    = 4'd5,
    C_SW    = 4'd6,
    C_BEQ   = 4'd7,
    C_J     = 4'd8,
    C_JAL   = 4'd9,
    C_HALT  = 4'd10
  } cls_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d, cls_dec;
  logic [5:0]  funct_q, funct_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] retired_q;
  logic        retire;
  logic        wait_tick;

  // Instruction class from the decoded IR fields; HALT_OP takes priority.
  always_comb begin
    cls_dec = C_NOP;
    if (opecode == HALT_OP) begin
      cls_dec = C_HALT;
    end else begin
      case (opecode)
        6'h00:   cls_dec = (funct == 6'h08) ? C_JR : C_RTYPE;
        6'h08:   cls_dec = C_ADDI;
        6'h0D:   cls_dec = C_ORI;
        6'h23:   cls_dec = C_LW;
        6'h2B:   cls_dec = C_SW;
        6'h04:   cls_dec = C_BEQ;
        6'h02:   cls_dec = C_J;
        6'h03:   cls_dec = C_JAL;
        default: cls_dec = C_NOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NOP;
      funct_q   <= 6'd0;
      tmo_q     <= 8'd0;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      funct_q <= funct_d;
      tmo_q   <= tmo_d;
      if (retire) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  // Next state; the timeout counter only advances while parked in a wait state,
  // so any state change or ready clears it.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    funct_d   = funct_q;
    retire    = 1'b0;
    wait_tick = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_tick = 1'b1;
        end
      end
      S_DECODE: begin
        cls_d   = cls_dec;
        funct_d = funct;
        if (cls_dec == C_NOP) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_RTYPE, C_ADDI, C_ORI: state_d = S_WB;
          C_LW, C_SW:             state_d = S_MEM;
          C_BEQ, C_J, C_JAL, C_JR: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_HALT:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_tick = 1'b1;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
    tmo_d = wait_tick ? (tmo_q + 8'd1) : 8'd0;
  end

  // Outputs. Selects derive from the latched class, so they hold from EXEC through WB.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    lr_we     = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wb_src    = 1'b0;
    alu_src   = 1'b0;
    zors      = 1'b0;
    alu_funct = 6'd0;
    halted    = 1'b0;
    fault     = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cls_q)
        C_RTYPE: begin
          alu_funct = funct_q;
          reg_dst   = 1'b1;
        end
        C_ADDI: begin
          alu_src   = 1'b1;
          zors      = 1'b1;
          alu_funct = 6'h20;
        end
        C_ORI: begin
          alu_src   = 1'b1;
          alu_funct = 6'h25;
        end
        C_LW: begin
          alu_src   = 1'b1;
          zors      = 1'b1;
          alu_funct = 6'h20;
          wb_src    = 1'b1;
        end
        C_SW: begin
          alu_src   = 1'b1;
          zors      = 1'b1;
          alu_funct = 6'h20;
        end
        C_BEQ:   alu_funct = 6'h22;
        default: alu_funct = 6'd0;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_BEQ: begin
            pc_we  = alu_zero;
            pc_src = 2'd1;
          end
          C_J: begin
            pc_we  = 1'b1;
            pc_src = 2'd2;
          end
          C_JAL: begin
            pc_we  = 1'b1;
            pc_src = 2'd2;
            lr_we  = 1'b1;
          end
          C_JR: begin
            pc_we  = 1'b1;
            pc_src = 2'd3;
          end
          default: pc_src = 2'd0;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_SW);
      end
      S_WB:    reg_we = 1'b1;
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: each instruction is expanded into an expected
// per-cycle trace (inputs to drive + outputs required) and replayed against the DUT.
module tb_multicycle_controller;

  localparam int         TMO  = 64;
  localparam logic [5:0] HOP  = 6'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opecode, funct;
  logic        alu_zero, imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic        ir_we, pc_we, lr_we, reg_we, reg_dst, wb_src, alu_src, zors;
  logic [1:0]  pc_src;
  logic [5:0]  alu_funct;
  logic        halted, fault;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opecode(opecode), .funct(funct), .alu_zero(alu_zero),
    .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .lr_we(lr_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .wb_src(wb_src), .alu_src(alu_src), .zors(zors),
    .alu_funct(alu_funct), .halted(halted), .fault(fault), .retired(retired)
  );

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       lr_we, reg_we, reg_dst, wb_src, alu_src, zors;
    logic [5:0] alu_funct;
    logic       halted, fault;
  } out_t;

  typedef struct {
    logic irdy;
    logic drdy;
    out_t e;
    out_t m;
  } rec_t;

  rec_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_ret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic out_t observe();
    out_t o;
    o.imem_req = imem_req; o.dmem_req = dmem_req; o.dmem_we = dmem_we; o.ir_we = ir_we;
    o.pc_we = pc_we; o.pc_src = pc_src; o.lr_we = lr_we; o.reg_we = reg_we;
    o.reg_dst = reg_dst; o.wb_src = wb_src; o.alu_src = alu_src; o.zors = zors;
    o.alu_funct = alu_funct; o.halted = halted; o.fault = fault;
    return o;
  endfunction

  function automatic out_t no_sel();
    out_t m;
    m = '1;
    m.alu_src = 1'b0; m.zors = 1'b0; m.alu_funct = '0; m.reg_dst = 1'b0; m.wb_src = 1'b0;
    return m;
  endfunction

  function automatic void push(input logic irdy, input logic drdy, input out_t e, input out_t m);
    rec_t r;
    r.irdy = irdy; r.drdy = drdy; r.e = e; r.m = m;
    q.push_back(r);
  endfunction

  // Terminal states: a few cycles with both readies high to show nothing exits.
  function automatic void trailer(input bit is_fault);
    out_t e;
    for (int k = 0; k < 3; k++) begin
      e = '0;
      e.fault  = is_fault;
      e.halted = !is_fault;
      push(1'b1, 1'b1, e, no_sel());
    end
  endfunction

  // Builds the expected trace for one instruction; returns 1 if it retires.
  function automatic int build(input logic [5:0] op, input logic [5:0] fn,
                               input int di, input int dd, input logic az);
    out_t e, s, m, mw;
    q.delete();
    for (int k = 0; k < di && k < TMO; k++) begin
      e = '0; e.imem_req = 1'b1;
      push(1'b0, 1'b0, e, no_sel());
    end
    if (di >= TMO) begin
      trailer(1'b1);
      return 0;
    end
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    push(1'b1, 1'b0, e, no_sel());
    e = '0;
    push(1'b0, 1'b0, e, no_sel());
    if (op == HOP) begin
      push(1'b0, 1'b0, e, no_sel());
      trailer(1'b0);
      return 0;
    end
    if (op == 6'h02 || op == 6'h03 || (op == 6'h00 && fn == 6'h08)) begin
      e = '0; e.pc_we = 1'b1;
      e.pc_src = (op == 6'h00) ? 2'd3 : 2'd2;
      e.lr_we  = (op == 6'h03);
      push(1'b0, 1'b0, e, no_sel());
      return 1;
    end
    s = '0;
    m = '1; m.reg_dst = 1'b0; m.wb_src = 1'b0;
    case (op)
      6'h00: begin s.alu_funct = fn; s.reg_dst = 1'b1; m.zors = 1'b0; end
      6'h08: begin s.alu_src = 1'b1; s.zors = 1'b1; s.alu_funct = 6'h20; end
      6'h0D: begin s.alu_src = 1'b1; s.alu_funct = 6'h25; end
      6'h23: begin s.alu_src = 1'b1; s.zors = 1'b1; s.alu_funct = 6'h20; s.wb_src = 1'b1; end
      6'h2B: begin s.alu_src = 1'b1; s.zors = 1'b1; s.alu_funct = 6'h20; end
      6'h04: begin
        s.alu_funct = 6'h22; m.zors = 1'b0;
        e = s; e.pc_we = az; e.pc_src = 2'd1;
        push(1'b0, 1'b0, e, m);
        return 1;
      end
      default: return 1;
    endcase
    push(1'b0, 1'b0, s, m);
    if (op == 6'h23 || op == 6'h2B) begin
      e = s; e.dmem_req = 1'b1; e.dmem_we = (op == 6'h2B);
      for (int k = 0; k < dd && k < TMO; k++) push(1'b0, 1'b0, e, m);
      if (dd >= TMO) begin
        trailer(1'b1);
        return 0;
      end
      push(1'b0, 1'b1, e, m);
      if (op == 6'h2B) return 1;
    end
    mw = m; mw.reg_dst = 1'b1; mw.wb_src = 1'b1;
    e = s; e.reg_we = 1'b1;
    push(1'b0, 1'b0, e, mw);
    return 1;
  endfunction

  task automatic play(input string name, input logic az, input int rst_at, output int ncyc);
    ncyc = 0;
    for (int i = 0; i < q.size(); i++) begin
      imem_ready = q[i].irdy;
      dmem_ready = q[i].drdy;
      alu_zero   = az;
      if (i == rst_at) rst = 1'b1;
      @(negedge clk);
      check($sformatf("%s c%0d", name, i), 32'(observe() & q[i].m), 32'(q[i].e & q[i].m));
      @(posedge clk); #1;
      ncyc++;
      if (i == rst_at) break;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int di, input int dd,
                     input logic az, output int ncyc);
    int r;
    opecode = op;
    funct   = fn;
    r = build(op, fn, di, dd, az);
    play($sformatf("op%02h", op), az, -1, ncyc);
    if (r != 0) exp_ret = exp_ret + 32'd1;
    check("retired", retired, exp_ret);
    $display("instr op=%02h fn=%02h di=%0d dd=%0d z=%0d cycles=%0d retired=%0d",
             op, fn, di, dd, az, ncyc, retired);
  endtask

  task automatic do_reset();
    out_t e;
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;
    opecode = 6'd0; funct = 6'd0;
    @(posedge clk); #1;
    exp_ret = 32'd0;
    e = '0; e.imem_req = 1'b1;
    check("rst_outs", 32'(observe()), 32'(e));
    check("rst_retired", retired, exp_ret);
    rst = 1'b0;
  endtask

  initial begin
    int          n, sel, di, dd;
    logic        az;
    logic [5:0]  op, fn;
    logic [5:0]  unk [4];
    unk = '{6'h01, 6'h05, 6'h10, 6'h3E};

    do_reset();
    run(6'h00, 6'h20, 0, 0, 1'b0, n);  check("add_cycles", n, 4);
    run(6'h23, 6'h00, 0, 3, 1'b0, n);  check("lw_cycles", n, 8);
    run(6'h04, 6'h00, 0, 0, 1'b1, n);
    run(6'h04, 6'h00, 1, 0, 1'b0, n);
    run(6'h03, 6'h00, 0, 0, 1'b0, n);
    run(6'h2B, 6'h00, 2, 1, 1'b0, n);
    run(6'h00, 6'h08, 0, 0, 1'b0, n);
    run(6'h11, 6'h00, 0, 0, 1'b0, n);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 10);
      fn  = 6'($urandom_range(0, 63));
      case (sel)
        0, 1:    begin op = 6'h00; if (fn == 6'h08) fn = 6'h21; end
        2:       begin op = 6'h00; fn = 6'h08; end
        3:       op = 6'h08;
        4:       op = 6'h0D;
        5:       op = 6'h23;
        6:       op = 6'h2B;
        7:       op = 6'h04;
        8:       op = 6'h02;
        9:       op = 6'h03;
        default: op = unk[$urandom_range(0, 3)];
      endcase
      di = $urandom_range(0, 5);
      dd = $urandom_range(0, 5);
      az = 1'($urandom_range(0, 1));
      run(op, fn, di, dd, az, n);
    end

    // Reset landing in the middle of a data access.
    opecode = 6'h23; funct = 6'h00;
    void'(build(6'h23, 6'h00, 1, 10, 1'b0));
    play("midrst", 1'b0, 6, n);
    rst = 1'b0;
    exp_ret = 32'd0;
    @(negedge clk);
    check("midrst_dmem_req", 32'(dmem_req), 32'd0);
    check("midrst_imem_req", 32'(imem_req), 32'd1);
    check("midrst_retired", retired, exp_ret);
    $display("instr midrst cycles=%0d retired=%0d", n, retired);
    do_reset();

    run(6'h00, 6'h25, 0, 0, 1'b0, n);
    run(HOP, 6'h00, 0, 0, 1'b0, n);
    check("halt_flag", 32'(halted), 32'd1);
    do_reset();

    run(6'h00, 6'h20, TMO, 0, 1'b0, n);
    check("fetch_tmo_fault", 32'(fault), 32'd1);
    do_reset();

    run(6'h00, 6'h20, TMO - 1, 0, 1'b0, n);
    check("fetch_tmo_edge_cycles", n, TMO + 3);
    check("fetch_tmo_edge_nofault", 32'(fault), 32'd0);

    run(6'h23, 6'h00, 0, TMO, 1'b0, n);
    check("mem_tmo_fault", 32'(fault), 32'd1);
    do_reset();

    run(6'h2B, 6'h00, 0, TMO - 1, 1'b0, n);
    check("mem_tmo_edge_nofault", 32'(fault), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
